// File: rtl/instmemory.sv
// Word-addressed instruction memory: combinational read port, synchronous write port, async clear.
// Latency: reads are combinational (zero cycles); writes land on the rising edge of clock.
// Backpressure: none; every write is accepted or silently dropped if its index is out of range.
module instmemory #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] instruct
);

    // Index width into the storage array; at least one bit so DEPTH=1 still elaborates.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Full-width limit so indices with any high bit set never alias into storage.
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    // Range checks use every address bit; DEPTH need not be a power of two.
    always_comb begin
        wr_in_range = (WriteReg < LIMIT);
        rd_in_range = (addr < LIMIT);
        wr_idx      = WriteReg[IDX_W-1:0];
        rd_idx      = addr[IDX_W-1:0];
    end

    // Storage: reset clears every word at once and blocks writes while held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (RegWrite && wr_in_range) begin
            mem[wr_idx] <= WriteData;
        end
    end

    // Read port: out-of-range indices return zero rather than wrapping.
    always_comb begin
        instruct = '0;
        if (rd_in_range) begin
            instruct = mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_instmemory.sv
// Directed bench for instmemory with a queue-based scoreboard.
// Stimulus pushes expected words and fires a sample strobe; a monitor pops and compares.
// All timing is derived from a 10 ns clock; no DUT-driven handshakes to wait on.
module tb_instmemory;

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] instruct;

    int vectors;
    int miscompares;

    logic [31:0] exp_q [$];
    string       nm_q  [$];
    event        smp;

    instmemory #(
        .DEPTH (256),
        .DATA_W(32),
        .ADDR_W(32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .RegWrite (RegWrite),
        .instruct (instruct)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: each sample strobe presents one output word; pop and compare.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(smp);
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sample_without_expect: got %08h, required nothing pending", instruct);
            end else begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                vectors++;
                if (instruct !== e) begin
                    miscompares++;
                    $display("FAIL %s: addr=%0h got %08h, required %08h", n, addr, instruct, e);
                end
            end
        end
    end

    // Drive a read address, settle, queue the expected word and strobe the monitor.
    task automatic chk(input logic [31:0] a, input logic [31:0] e, input string nm);
        addr = a;
        #1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        ->smp;
        #1;
    endtask

    // One write, set up on the falling edge and committed on the next rising edge.
    task automatic do_write(input logic [31:0] idx, input logic [31:0] d);
        @(negedge clock);
        WriteReg  = idx;
        WriteData = d;
        RegWrite  = 1'b1;
        @(posedge clock);
        #1;
        RegWrite  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        addr        = '0;
        WriteReg    = '0;
        WriteData   = '0;
        RegWrite    = 1'b0;

        // Reset state
        @(negedge clock);
        chk(32'd0, 32'h0000_0000, "reset_state_addr0");
        @(negedge clock);
        reset = 1'b0;

        // Async reset between edges clears a written word without any clock
        do_write(32'd5, 32'h5555_AAAA);
        chk(32'd5, 32'h5555_AAAA, "pre_reset_write5");
        @(negedge clock);
        #1;
        reset = 1'b1;
        chk(32'd0, 32'h0000_0000, "async_reset_addr0");
        chk(32'd5, 32'h0000_0000, "async_reset_addr5");
        reset = 1'b0;

        // Basic write/read
        do_write(32'd0, 32'h00A2_00B3);
        chk(32'd0, 32'h00A2_00B3, "basic_addr0");
        chk(32'd1, 32'h0000_0000, "basic_addr1_unwritten");

        // Multiple words, top index, overwrite
        do_write(32'd1,   32'h0050_0093);
        do_write(32'd255, 32'hFFF0_0113);
        chk(32'd1,   32'h0050_0093, "multi_addr1");
        chk(32'd255, 32'hFFF0_0113, "multi_addr255");
        do_write(32'd1, 32'h0000_0013);
        chk(32'd1, 32'h0000_0013, "overwrite_addr1");

        // Write enable low across several edges
        @(negedge clock);
        WriteReg  = 32'd2;
        WriteData = 32'hDEAD_BEEF;
        RegWrite  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk(32'd2, 32'h0000_0000, "we_low_addr2");

        // Out-of-range writes are dropped, no aliasing onto index 0
        do_write(32'd256,        32'h1234_5678);
        do_write(32'h8000_0000,  32'h8765_4321);
        chk(32'd256,        32'h0000_0000, "oor_read256");
        chk(32'hFFFF_FFFF,  32'h0000_0000, "oor_read_max");
        chk(32'd0,          32'h00A2_00B3, "oor_addr0_unchanged");

        // Same-index read-during-write at index 3
        do_write(32'd3, 32'h1111_1111);
        @(negedge clock);
        WriteReg  = 32'd3;
        WriteData = 32'hCAFE_F00D;
        RegWrite  = 1'b1;
        chk(32'd3, 32'h1111_1111, "rdw_before_edge");
        @(posedge clock);
        #1;
        RegWrite = 1'b0;
        chk(32'd3, 32'hCAFE_F00D, "rdw_after_edge");

        // Write one index while reading another
        @(negedge clock);
        WriteReg  = 32'd4;
        WriteData = 32'h0444_0444;
        RegWrite  = 1'b1;
        @(posedge clock);
        #1;
        RegWrite = 1'b0;
        chk(32'd1, 32'h0000_0013, "indep_read_addr1");
        chk(32'd4, 32'h0444_0444, "indep_write_addr4");

        // Half-period reset pulse with a write attempt pending across the edge
        @(negedge clock);
        #1;
        WriteReg  = 32'd7;
        WriteData = 32'h7777_7777;
        RegWrite  = 1'b1;
        reset     = 1'b1;
        #5;
        reset    = 1'b0;
        RegWrite = 1'b0;
        chk(32'd0,   32'h0000_0000, "midrst_addr0");
        chk(32'd1,   32'h0000_0000, "midrst_addr1");
        chk(32'd3,   32'h0000_0000, "midrst_addr3");
        chk(32'd4,   32'h0000_0000, "midrst_addr4");
        chk(32'd255, 32'h0000_0000, "midrst_addr255");
        chk(32'd7,   32'h0000_0000, "midrst_write_blocked7");
        do_write(32'd6, 32'h0066_0066);
        chk(32'd6, 32'h0066_0066, "post_reset_write6");

        // Drain: any expectation the monitor never consumed is a failure
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
